// File: rtl/project1_nios2_qsys_0_oci_dct_pkg.sv
// Shared constants and types for the OCI data-trace compression (DCT) code packer.
package project1_nios2_qsys_0_oci_dct_pkg;

  localparam int unsigned DCT_CODE_W  = 2;
  localparam int unsigned DCT_ENTRIES = 15;
  localparam int unsigned DCT_FRAME_W = DCT_ENTRIES * DCT_CODE_W;
  localparam int unsigned DCT_COUNT_W = 4;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    ENDED
  } dct_state_e;

endpackage

// File: rtl/project1_nios2_qsys_0_oci_dct_outreg.sv
// Valid/ready holding register for one DCT frame and its entry count.
module project1_nios2_qsys_0_oci_dct_outreg
  import project1_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DCT_FRAME_W-1:0] load_buffer,
  input  logic [DCT_COUNT_W-1:0] load_count,
  input  logic                   dct_ready,
  output logic [DCT_FRAME_W-1:0] dct_buffer,
  output logic [DCT_COUNT_W-1:0] dct_count,
  output logic                   dct_valid,
  output logic                   slot_free
);

  assign slot_free = !dct_valid | dct_ready;

  // load is only raised by the packer while slot_free is set
  always_ff @(posedge clk) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end else if (load) begin
      dct_buffer <= load_buffer;
      dct_count  <= load_count;
      dct_valid  <= 1'b1;
    end else if (dct_ready) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/project1_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT codes into 30-bit frames and sequences the end-of-test drain.
// Optional: define DCT_DROP_COUNT_EN to drop (and count) codes instead of stalling.
module project1_nios2_qsys_0_oci_dct_packer
  import project1_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dct_code_valid,
  input  logic [DCT_CODE_W-1:0]  dct_code,
  output logic                   dct_code_ready,
  input  logic                   flush,
  input  logic                   trace_stop,
  output logic [DCT_FRAME_W-1:0] dct_buffer,
  output logic [DCT_COUNT_W-1:0] dct_count,
  output logic                   dct_valid,
  input  logic                   dct_ready,
  output logic                   test_ending,
  output logic                   test_has_ended
`ifdef DCT_DROP_COUNT_EN
  ,
  output logic [7:0]             dct_drop_count
`endif
);

  localparam logic [DCT_COUNT_W-1:0] CNT_LAST = DCT_COUNT_W'(DCT_ENTRIES - 1);
  localparam logic [DCT_COUNT_W-1:0] CNT_FULL = DCT_COUNT_W'(DCT_ENTRIES);

  dct_state_e             state_q, state_d;
  logic [DCT_FRAME_W-1:0] acc_q, acc_d, acc_nx;
  logic [DCT_COUNT_W-1:0] acc_cnt_q, acc_cnt_d, cnt_nx;
  logic                   flush_pend_q, flush_pend_d;
  logic                   slot_free, normal_ready, accept, flush_req, emit;

  always_comb begin
    normal_ready = (state_q == FILL) & !flush_pend_q & ((acc_cnt_q < CNT_LAST) | slot_free);
    accept       = dct_code_valid & normal_ready;
    acc_nx       = acc_q;
    cnt_nx       = acc_cnt_q;
    if (accept) begin
      acc_nx = {acc_q[DCT_FRAME_W-DCT_CODE_W-1:0], dct_code};
      cnt_nx = acc_cnt_q + 1'b1;
    end
    flush_req = (state_q == FILL) & (flush | flush_pend_q);
    // A full accumulator always has a free slot, since the last code stalls otherwise
    emit = (cnt_nx == CNT_FULL) |
           ((flush_req | (state_q == DRAIN)) & (cnt_nx != '0) & slot_free);
    flush_pend_d = flush_req & (cnt_nx != '0) & !emit;
    acc_d        = emit ? '0 : acc_nx;
    acc_cnt_d    = emit ? '0 : cnt_nx;

    state_d = state_q;
    unique case (state_q)
      FILL:    if (trace_stop) state_d = DRAIN;
      DRAIN:   if ((acc_cnt_q == '0) & slot_free) state_d = ENDED;
      ENDED:   state_d = ENDED;
      default: state_d = FILL;
    endcase
  end

`ifdef DCT_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;
  logic       drop;

  assign dct_code_ready = (state_q == FILL);
  assign drop           = dct_code_valid & (state_q == FILL) & !normal_ready;
  assign dct_drop_count = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
`else
  assign dct_code_ready = normal_ready;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FILL;
      acc_q          <= '0;
      acc_cnt_q      <= '0;
      flush_pend_q   <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      acc_cnt_q      <= acc_cnt_d;
      flush_pend_q   <= flush_pend_d;
      test_ending    <= (state_d != FILL);
      test_has_ended <= (state_d == ENDED);
    end
  end

  project1_nios2_qsys_0_oci_dct_outreg u_outreg (
    .clk         (clk),
    .reset       (reset),
    .load        (emit),
    .load_buffer (acc_nx),
    .load_count  (cnt_nx),
    .dct_ready   (dct_ready),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .dct_valid   (dct_valid),
    .slot_free   (slot_free)
  );

endmodule

// File: tb/tb_project1_nios2_qsys_0_oci_dct_packer.sv
// Directed and randomized bench for the DCT packer against a queue-based reference model.
module tb_project1_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dct_code_valid = 1'b0;
  logic [1:0]  dct_code = 2'b00;
  logic        dct_code_ready;
  logic        flush = 1'b0;
  logic        trace_stop = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready = 1'b1;
  logic        test_ending;
  logic        test_has_ended;
`ifdef DCT_DROP_COUNT_EN
  logic [7:0]  dct_drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          mq[$];
  bit          m_pend;
  int          m_st;     // 0 fill, 1 drain, 2 ended
  bit          m_v;
  int          m_cnt;
  logic [29:0] m_buf;
  int          m_drop;

  always #5 clk = ~clk;

  project1_nios2_qsys_0_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .dct_code_valid (dct_code_valid),
    .dct_code       (dct_code),
    .dct_code_ready (dct_code_ready),
    .flush          (flush),
    .trace_stop     (trace_stop),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
`ifdef DCT_DROP_COUNT_EN
    ,
    .dct_drop_count (dct_drop_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] frame_value();
    logic [29:0] r = '0;
    int n = mq.size();
    for (int i = 0; i < n; i++) r = r + 30'(mq[i] * (4 ** (n - 1 - i)));
    return r;
  endfunction

  function automatic bit norm_ready(input bit rd);
    return m_st == 0 && !m_pend && (mq.size() < 14 || !m_v || rd);
  endfunction

  function automatic bit exp_ready(input bit rd);
`ifdef DCT_DROP_COUNT_EN
    return m_st == 0;
`else
    return norm_ready(rd);
`endif
  endfunction

  task automatic model_step(input bit v, input bit [1:0] c, input bit fl, input bit ts,
                            input bit rd, input bit rst);
    bit sf, nr, want, emit;
    int n;
    if (rst) begin
      mq.delete(); m_pend = 0; m_st = 0; m_v = 0; m_cnt = 0; m_buf = '0; m_drop = 0;
      return;
    end
    sf = !m_v || rd;
    nr = norm_ready(rd);
    if (v && nr) mq.push_back(int'(c));
    if (v && m_st == 0 && !nr && m_drop < 255) m_drop++;
    n    = mq.size();
    want = (m_st == 0 && (fl || m_pend)) || m_st == 1;
    emit = (n == 15) || (want && n > 0 && sf);
    m_pend = (m_st == 0) && (fl || m_pend) && n > 0 && !emit;
    if (emit) begin
      m_v = 1; m_cnt = n; m_buf = frame_value(); mq.delete();
    end else if (sf) begin
      m_v = 0; m_cnt = 0; m_buf = '0;
    end
    if (m_st == 0 && ts) m_st = 1;
    else if (m_st == 1 && n == 0 && sf) m_st = 2;
  endtask

  task automatic compare_all();
    check_eq("code_ready", 32'(dct_code_ready), 32'(exp_ready(dct_ready)));
    check_eq("valid", 32'(dct_valid), 32'(m_v));
    check_eq("count", 32'(dct_count), 32'(m_cnt));
    check_eq("buffer", 32'(dct_buffer), 32'(m_buf));
    check_eq("test_ending", 32'(test_ending), 32'(m_st != 0));
    check_eq("test_has_ended", 32'(test_has_ended), 32'(m_st == 2));
`ifdef DCT_DROP_COUNT_EN
    check_eq("drop_count", 32'(dct_drop_count), 32'(m_drop));
`endif
  endtask

  task automatic cyc(input bit v, input bit [1:0] c, input bit fl, input bit ts,
                     input bit rd, input bit rst);
    dct_code_valid = v; dct_code = c; flush = fl; trace_stop = ts;
    dct_ready = rd; reset = rst;
    model_step(v, c, fl, ts, rd, rst);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    // reset state
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    check_eq("rst_valid", 32'(dct_valid), 32'd0);
    check_eq("rst_ready", 32'(dct_code_ready), 32'd1);

    // full frame of 01 codes
    for (int i = 0; i < 15; i++) cyc(1, 2'b01, 0, 0, 1, 0);
    check_eq("t1_valid", 32'(dct_valid), 32'd1);
    check_eq("t1_count", 32'(dct_count), 32'd15);
    check_eq("t1_buf", 32'(dct_buffer), 32'h15555555);
    cyc(0, 0, 0, 0, 1, 0);
    check_eq("t1_valid_drop", 32'(dct_valid), 32'd0);

    // partial flush, then flush on empty accumulator
    cyc(1, 2'b11, 0, 0, 1, 0);
    cyc(1, 2'b10, 0, 0, 1, 0);
    cyc(1, 2'b01, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    check_eq("t2_count", 32'(dct_count), 32'd3);
    check_eq("t2_buf", 32'(dct_buffer), 32'h39);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    check_eq("t2_empty_flush", 32'(dct_valid), 32'd0);

    // backpressure: slot held, 14 more codes, 15th stalls until dct_ready
    for (int i = 0; i < 15; i++) cyc(1, 2'b01, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(1, 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b11, 0, 0, 0, 0);
      check_eq("t3_stall", 32'(dct_code_ready), 32'd0);
      check_eq("t3_held", 32'(dct_buffer), 32'h15555555);
    end
    cyc(1, 2'b11, 0, 0, 1, 0);
    check_eq("t3_second_cnt", 32'(dct_count), 32'd15);
    check_eq("t3_second_buf", 32'(dct_buffer), 32'h3FFFFFFF);
    cyc(0, 0, 0, 0, 1, 0);

    // end-of-test drain
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 2'(i), 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check_eq("t4_ending", 32'(test_ending), 32'd1);
    check_eq("t4_ready", 32'(dct_code_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 2'b01, 0, 0, 0, 0);
      if (i > 0) check_eq("t4_held_cnt", 32'(dct_count), 32'd5);
      check_eq("t4_not_ended", 32'(test_has_ended), 32'd0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    check_eq("t4_ended", 32'(test_has_ended), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b10, 1, 1, 1, 0);
      check_eq("t4_sticky", 32'(test_has_ended), 32'd1);
    end

    // mid-frame reset discards, then a full frame of 10 codes
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) cyc(1, 2'b11, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check_eq("t5_valid", 32'(dct_valid), 32'd0);
    check_eq("t5_ready", 32'(dct_code_ready), 32'd1);
    check_eq("t5_ending", 32'(test_ending), 32'd0);
    for (int i = 0; i < 15; i++) cyc(1, 2'b10, 0, 0, 1, 0);
    check_eq("t5_buf", 32'(dct_buffer), 32'h2AAAAAAA);
    check_eq("t5_cnt", 32'(dct_count), 32'd15);

`ifdef DCT_DROP_COUNT_EN
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 40; i++) cyc(1, 2'b01, 0, 0, 0, 0);
    check_eq("drop_total", 32'(dct_drop_count), 32'd11);
    check_eq("drop_held", 32'(dct_count), 32'd15);
`endif

    // randomized traffic
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 9) < 7, 2'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 299) == 0, $urandom_range(0, 9) < 6,
          $urandom_range(0, 399) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
